// File: rtl/noc_credit_vc_rx_if.sv
// Credit-link receive bundle: upstream flit link, credit return and switch-side head/pop signals.
// master = upstream transmitter plus local switch; slave = the receive block.
interface noc_credit_vc_rx_if #(
  parameter int VC_W = 3,
  parameter int X_W  = 2,
  parameter int Y_W  = 2,
  parameter int D_W  = 32
);
  logic            link_v;
  logic [VC_W-1:0] link_vc;
  logic [X_W-1:0]  link_x;
  logic [Y_W-1:0]  link_y;
  logic [D_W-1:0]  link_d;
  logic            cr_v;
  logic [VC_W-1:0] cr_vc;
  logic [VC_W-1:0] o_v;
  logic [X_W-1:0]  o_x;
  logic [Y_W-1:0]  o_y;
  logic [D_W-1:0]  o_d;
  logic [VC_W-1:0] o_sel;
  logic [VC_W-1:0] i_pop;
  logic            err;
  logic            empty;

  modport master (
    output link_v, link_vc, link_x, link_y, link_d, i_pop,
    input  cr_v, cr_vc, o_v, o_x, o_y, o_d, o_sel, err, empty
  );

  modport slave (
    input  link_v, link_vc, link_x, link_y, link_d, i_pop,
    output cr_v, cr_vc, o_v, o_x, o_y, o_d, o_sel, err, empty
  );
endinterface

// File: rtl/noc_credit_vc_rx.sv
// Per-VC credit link receiver: one FIFO per VC, lowest-index head mux, one credit per pop.
// Optional protocol checking with sticky err is enabled by defining NOC_CREDIT_RX_CHECK_EN.
module noc_credit_vc_rx #(
  parameter int VC_W  = 3,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 32,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  noc_credit_vc_rx_if.slave ifc
);
  localparam int FLIT_W = X_W + Y_W + D_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [VC_W-1:0]   nonempty;
  logic [VC_W-1:0]   wr_en;
  logic [VC_W-1:0]   pop_en;
  logic [VC_W-1:0]   sel;
  logic [FLIT_W-1:0] flit_in;
  logic [FLIT_W-1:0] head [VC_W];
  logic [FLIT_W-1:0] head_sel;
  logic              wr_legal;
  logic              pop_legal;
  logic              cr_v_reg;
  logic [VC_W-1:0]   cr_vc_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef NOC_CREDIT_RX_CHECK_EN
  logic [VC_W-1:0] full;
  logic            bad;
  logic            err_reg;

  // Full is judged on the pre-edge count: a same-cycle pop's credit has not reached upstream yet.
  assign wr_legal  = $onehot(ifc.link_vc) && ((ifc.link_vc & full) == '0);
  assign pop_legal = $onehot0(ifc.i_pop);
  assign bad       = (ifc.link_v && !wr_legal) || !pop_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (bad) begin
      err_reg <= 1'b1;
    end
  end

  assign ifc.err = err_reg;
`else
  assign wr_legal  = 1'b1;
  assign pop_legal = 1'b1;
  assign ifc.err   = 1'b0;
`endif

  assign flit_in = {ifc.link_x, ifc.link_y, ifc.link_d};
  assign wr_en   = (ifc.link_v && wr_legal) ? ifc.link_vc : '0;
  assign pop_en  = pop_legal ? (ifc.i_pop & nonempty) : '0;

  generate
    for (genvar gi = 0; gi < VC_W; gi++) begin : g_vc
      logic [FLIT_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  cnt_reg;

      // Storage needs no reset: only occupied slots are ever presented.
      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[wr_ptr_reg] <= flit_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (wr_en[gi]) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
          end
          if (pop_en[gi]) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
          end
          cnt_reg <= cnt_reg + CNT_W'(wr_en[gi]) - CNT_W'(pop_en[gi]);
        end
      end

      assign nonempty[gi] = (cnt_reg != '0);
      assign head[gi]     = mem[rd_ptr_reg];
`ifdef NOC_CREDIT_RX_CHECK_EN
      assign full[gi]     = (cnt_reg == CNT_W'(DEPTH));
`endif
    end
  endgenerate

  // Isolate the lowest set bit of the non-empty mask.
  assign sel = nonempty & (~nonempty + 1'b1);

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < VC_W; i++) begin
      head_sel = head_sel | ({FLIT_W{sel[i]}} & head[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_v_reg  <= 1'b0;
      cr_vc_reg <= '0;
    end else begin
      cr_v_reg  <= |pop_en;
      cr_vc_reg <= pop_en;
    end
  end

  assign ifc.o_v   = nonempty;
  assign ifc.o_sel = sel;
  assign {ifc.o_x, ifc.o_y, ifc.o_d} = head_sel;
  assign ifc.cr_v  = cr_v_reg;
  assign ifc.cr_vc = cr_vc_reg;
  assign ifc.empty = (nonempty == '0) && !ifc.link_v;
endmodule

// File: tb/tb_noc_credit_vc_rx.sv
// Bench for noc_credit_vc_rx: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_noc_credit_vc_rx;
  localparam int VC_W  = 3;
  localparam int X_W   = 2;
  localparam int Y_W   = 2;
  localparam int D_W   = 32;
  localparam int DEPTH = 4;
  localparam int F_W   = X_W + Y_W + D_W;

  typedef struct {
    logic        wv;
    logic [2:0]  wvc;
    logic [1:0]  wx;
    logic [1:0]  wy;
    logic [31:0] wd;
    logic [2:0]  pop;
    logic [2:0]  ov;
    logic [2:0]  sel;
    logic [1:0]  ex;
    logic [1:0]  ey;
    logic [31:0] ed;
    logic        crv;
    logic [2:0]  crvc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  noc_credit_vc_rx_if #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W)) ifc ();

  noc_credit_vc_rx #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ifc  (ifc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [2:0] wvc, input logic [1:0] x,
                       input logic [1:0] y, input logic [31:0] d, input logic [2:0] pop);
    ifc.link_v  = wv;
    ifc.link_vc = wvc;
    ifc.link_x  = x;
    ifc.link_y  = y;
    ifc.link_d  = d;
    ifc.i_pop   = pop;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check outputs before any clock edge, release on a falling edge.
  task automatic do_reset(input string tag);
    drive(1'b0, 3'b000, 2'd0, 2'd0, 32'd0, 3'b000);
    rst_n = 1'b0;
    #2;
    chk({tag, "_rst_o_v"}, 64'(ifc.o_v), 64'd0);
    chk({tag, "_rst_o_sel"}, 64'(ifc.o_sel), 64'd0);
    chk({tag, "_rst_cr_v"}, 64'(ifc.cr_v), 64'd0);
    chk({tag, "_rst_cr_vc"}, 64'(ifc.cr_vc), 64'd0);
    chk({tag, "_rst_err"}, 64'(ifc.err), 64'd0);
    chk({tag, "_rst_empty"}, 64'(ifc.empty), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [20];
  logic [F_W-1:0] mq [VC_W][$];

  initial begin
    drive(1'b0, 3'b000, 2'd0, 2'd0, 32'd0, 3'b000);
    #12;
    do_reset("init");

    // Write/head visibility, in-order drain with credits, head mux, write+pop at count 1, empty pop.
    tbl[0]  = '{1'b1, 3'b010, 2'd1, 2'd2, 32'hA5, 3'b000, 3'b010, 3'b010, 2'd1, 2'd2, 32'hA5, 1'b0, 3'b000};
    tbl[1]  = '{1'b1, 3'b001, 2'd0, 2'd0, 32'h1,  3'b000, 3'b011, 3'b001, 2'd0, 2'd0, 32'h1,  1'b0, 3'b000};
    tbl[2]  = '{1'b1, 3'b001, 2'd0, 2'd0, 32'h2,  3'b000, 3'b011, 3'b001, 2'd0, 2'd0, 32'h1,  1'b0, 3'b000};
    tbl[3]  = '{1'b1, 3'b001, 2'd0, 2'd0, 32'h3,  3'b000, 3'b011, 3'b001, 2'd0, 2'd0, 32'h1,  1'b0, 3'b000};
    tbl[4]  = '{1'b1, 3'b001, 2'd0, 2'd0, 32'h4,  3'b000, 3'b011, 3'b001, 2'd0, 2'd0, 32'h1,  1'b0, 3'b000};
    tbl[5]  = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b001, 3'b011, 3'b001, 2'd0, 2'd0, 32'h2,  1'b1, 3'b001};
    tbl[6]  = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b001, 3'b011, 3'b001, 2'd0, 2'd0, 32'h3,  1'b1, 3'b001};
    tbl[7]  = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b001, 3'b011, 3'b001, 2'd0, 2'd0, 32'h4,  1'b1, 3'b001};
    tbl[8]  = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b001, 3'b010, 3'b010, 2'd1, 2'd2, 32'hA5, 1'b1, 3'b001};
    tbl[9]  = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b000, 3'b010, 3'b010, 2'd1, 2'd2, 32'hA5, 1'b0, 3'b000};
    tbl[10] = '{1'b1, 3'b001, 2'd3, 2'd1, 32'h9,  3'b000, 3'b011, 3'b001, 2'd3, 2'd1, 32'h9,  1'b0, 3'b000};
    tbl[11] = '{1'b1, 3'b100, 2'd0, 2'd0, 32'h7,  3'b000, 3'b111, 3'b001, 2'd3, 2'd1, 32'h9,  1'b0, 3'b000};
    tbl[12] = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b100, 3'b011, 3'b001, 2'd3, 2'd1, 32'h9,  1'b1, 3'b100};
    tbl[13] = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b010, 3'b001, 3'b001, 2'd3, 2'd1, 32'h9,  1'b1, 3'b010};
    tbl[14] = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b001, 3'b000, 3'b000, 2'd0, 2'd0, 32'h0,  1'b1, 3'b001};
    tbl[15] = '{1'b1, 3'b010, 2'd2, 2'd3, 32'h11, 3'b000, 3'b010, 3'b010, 2'd2, 2'd3, 32'h11, 1'b0, 3'b000};
    tbl[16] = '{1'b1, 3'b010, 2'd1, 2'd1, 32'h22, 3'b010, 3'b010, 3'b010, 2'd1, 2'd1, 32'h22, 1'b1, 3'b010};
    tbl[17] = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b000, 3'b010, 3'b010, 2'd1, 2'd1, 32'h22, 1'b0, 3'b000};
    tbl[18] = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b010, 3'b000, 3'b000, 2'd0, 2'd0, 32'h0,  1'b1, 3'b010};
    tbl[19] = '{1'b0, 3'b000, 2'd0, 2'd0, 32'h0,  3'b100, 3'b000, 3'b000, 2'd0, 2'd0, 32'h0,  1'b0, 3'b000};

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].wv, tbl[i].wvc, tbl[i].wx, tbl[i].wy, tbl[i].wd, tbl[i].pop);
      step();
      $display("vec %0d: wv=%0b vc=%b d=0x%0h pop=%b -> o_v=%b o_sel=%b o_d=0x%0h cr_v=%0b cr_vc=%b",
               i, tbl[i].wv, tbl[i].wvc, tbl[i].wd, tbl[i].pop, ifc.o_v, ifc.o_sel, ifc.o_d,
               ifc.cr_v, ifc.cr_vc);
      chk($sformatf("vec%0d_o_v", i), 64'(ifc.o_v), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_o_sel", i), 64'(ifc.o_sel), 64'(tbl[i].sel));
      chk($sformatf("vec%0d_o_x", i), 64'(ifc.o_x), 64'(tbl[i].ex));
      chk($sformatf("vec%0d_o_y", i), 64'(ifc.o_y), 64'(tbl[i].ey));
      chk($sformatf("vec%0d_o_d", i), 64'(ifc.o_d), 64'(tbl[i].ed));
      chk($sformatf("vec%0d_cr_v", i), 64'(ifc.cr_v), 64'(tbl[i].crv));
      chk($sformatf("vec%0d_cr_vc", i), 64'(ifc.cr_vc), 64'(tbl[i].crvc));
      chk($sformatf("vec%0d_err", i), 64'(ifc.err), 64'd0);
      chk($sformatf("vec%0d_empty", i), 64'(ifc.empty), 64'(tbl[i].ov == 3'b000 && !tbl[i].wv));
    end

    // Async reset mid-stream while a credit is outstanding.
    drive(1'b1, 3'b010, 2'd0, 2'd0, 32'h31, 3'b000);
    step();
    drive(1'b1, 3'b010, 2'd0, 2'd0, 32'h32, 3'b010);
    step();
    $display("pre-reset: o_v=%b cr_v=%0b o_d=0x%0h", ifc.o_v, ifc.cr_v, ifc.o_d);
    chk("midrst_pre_cr_v", 64'(ifc.cr_v), 64'd1);
    chk("midrst_pre_o_v", 64'(ifc.o_v), 64'(3'b010));
    chk("midrst_pre_o_d", 64'(ifc.o_d), 64'h32);
    do_reset("midrst");
    step();
    chk("midrst_post_o_v", 64'(ifc.o_v), 64'd0);

`ifdef NOC_CREDIT_RX_CHECK_EN
    // Overflow with same-cycle pop: flit dropped, pop still happens.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 3'b010, 2'd0, 2'd0, 32'h40 + 32'(k), 3'b000);
      step();
    end
    drive(1'b1, 3'b010, 2'd0, 2'd0, 32'h99, 3'b010);
    step();
    $display("overflow: err=%0b cr_v=%0b o_d=0x%0h", ifc.err, ifc.cr_v, ifc.o_d);
    chk("ovf_err", 64'(ifc.err), 64'd1);
    chk("ovf_cr_v", 64'(ifc.cr_v), 64'd1);
    chk("ovf_o_d", 64'(ifc.o_d), 64'h42);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b000, 2'd0, 2'd0, 32'd0, 3'b010);
      step();
      if (k < 2) chk($sformatf("ovf_drain%0d_o_d", k), 64'(ifc.o_d), 64'h43 + 64'(k));
      chk($sformatf("ovf_drain%0d_o_v", k), 64'(ifc.o_v), (k < 2) ? 64'(3'b010) : 64'd0);
      chk($sformatf("ovf_drain%0d_err", k), 64'(ifc.err), 64'd1);
    end
    do_reset("ovf");

    // Non-one-hot link_vc: flit dropped, err set.
    drive(1'b1, 3'b011, 2'd0, 2'd0, 32'h55, 3'b000);
    step();
    chk("badvc_err", 64'(ifc.err), 64'd1);
    chk("badvc_o_v", 64'(ifc.o_v), 64'd0);
    do_reset("badvc");

    // Non-one-hot pop: ignored, err set.
    drive(1'b1, 3'b001, 2'd0, 2'd0, 32'h61, 3'b000);
    step();
    drive(1'b1, 3'b010, 2'd0, 2'd0, 32'h62, 3'b000);
    step();
    drive(1'b0, 3'b000, 2'd0, 2'd0, 32'd0, 3'b011);
    step();
    chk("badpop_err", 64'(ifc.err), 64'd1);
    chk("badpop_o_v", 64'(ifc.o_v), 64'(3'b011));
    chk("badpop_cr_v", 64'(ifc.cr_v), 64'd0);
    do_reset("badpop");
`endif

    // Randomized legal traffic against the queue model.
    for (int v = 0; v < VC_W; v++) mq[v].delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        wv;
      int          wk;
      int          pk;
      logic [2:0]  wvc;
      logic [2:0]  pop;
      logic [2:0]  exp_cr;
      logic [2:0]  exp_ov;
      logic [2:0]  exp_sel;
      logic [F_W-1:0] exp_head;
      logic [F_W-1:0] flit;
      wk   = int'($urandom_range(0, VC_W - 1));
      wv   = ($urandom_range(0, 99) < 60) && (mq[wk].size() < DEPTH);
      wvc  = wv ? 3'(1 << wk) : 3'b000;
      flit = {2'($urandom), 2'($urandom), 32'($urandom)};
      pk   = int'($urandom_range(0, VC_W));
      pop  = (pk < VC_W) ? 3'(1 << pk) : 3'b000;
      drive(wv, wvc, flit[F_W-1 -: 2], flit[F_W-3 -: 2], flit[31:0], pop);

      exp_cr = 3'b000;
      if (pk < VC_W && mq[pk].size() > 0) begin
        void'(mq[pk].pop_front());
        exp_cr = pop;
      end
      if (wv) mq[wk].push_back(flit);

      step();

      exp_ov   = 3'b000;
      exp_sel  = 3'b000;
      exp_head = '0;
      for (int v = VC_W - 1; v >= 0; v--) begin
        if (mq[v].size() > 0) begin
          exp_ov[v] = 1'b1;
          exp_sel   = 3'(1 << v);
          exp_head  = mq[v][0];
        end
      end
      $display("rnd %0d: wv=%0b vc=%b pop=%b -> o_v=%b o_sel=%b cr_vc=%b", cyc, wv, wvc, pop,
               ifc.o_v, ifc.o_sel, ifc.cr_vc);
      chk($sformatf("rnd%0d_o_v", cyc), 64'(ifc.o_v), 64'(exp_ov));
      chk($sformatf("rnd%0d_o_sel", cyc), 64'(ifc.o_sel), 64'(exp_sel));
      chk($sformatf("rnd%0d_head", cyc), 64'({ifc.o_x, ifc.o_y, ifc.o_d}), 64'(exp_head));
      chk($sformatf("rnd%0d_cr_v", cyc), 64'(ifc.cr_v), 64'(exp_cr != 3'b000));
      chk($sformatf("rnd%0d_cr_vc", cyc), 64'(ifc.cr_vc), 64'(exp_cr));
      chk($sformatf("rnd%0d_err", cyc), 64'(ifc.err), 64'd0);
      chk($sformatf("rnd%0d_empty", cyc), 64'(ifc.empty), 64'(exp_ov == 3'b000 && !wv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
